button_conditioner: RTL
=======================

# button_conditioner

Conditions the raw game push-buttons into clean single-cycle `pushed` pulses for the mode state machine and the note-input logic. Each button passes through a two-flop synchronizer, an optional per-button stability debouncer and a rising-edge detector. The block sits between the board pins and `state_fsm`: `pushed[3]` and `pushed[4]` drive its `pushed_3` and `pushed_4` inputs. It runs on the 12 MHz system clock.

## Interface
- `NUM_BTN`, default 5: number of buttons conditioned; must be ≥1.
- `DEBOUNCE_CYCLES`, default 12000 (1 ms at 12 MHz): consecutive stable cycles required before accepting a level change; must be ≥2.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)`: width of each debounce counter; derived, not overridden.

Ports:
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `btn_in` in `NUM_BTN`: raw asynchronous button pins, active-high.
- `btn_level` out `NUM_BTN`: debounced button level.
- `pushed` out `NUM_BTN`: one-cycle pulse on each accepted 0→1 transition of `btn_level`.
- `released` out `NUM_BTN`: one-cycle pulse on each accepted 1→0 transition of `btn_level`.
- `any_pushed` out 1: OR-reduction of `pushed`, registered in the same cycle.

## Operation
- Each bit is fully independent. Per bit, the state is `sync1`, `sync2`, the counter `cnt[CNT_W-1:0]` and `level`.
- `sync1 <= btn_in[i]` and `sync2 <= sync1` on every edge.
- Debounce, when `sync2 == level`:
  - `cnt <= 0`.
- Debounce, when `sync2 != level` and `cnt == DEBOUNCE_CYCLES-1`:
  - `level <= sync2` and `cnt <= 0`.
  - `pushed[i] <= sync2`, `released[i] <= ~sync2`.
- Debounce, when `sync2 != level` otherwise:
  - `cnt <= cnt + 1`.
- `pushed`, `released` and `any_pushed` are registered and are 0 in every cycle not listed above.
- A held button yields exactly one `pushed` pulse. No auto-repeat.
- A bounce that returns to `level` before the count completes clears `cnt`, and no edge is produced.
- Simultaneous presses on several bits each pulse in their own acceptance cycle. Equal histories give the same cycle.
- Reset:
  - All flops go to 0, including `sync1`, `sync2`, `cnt` and `level`.
  - Every output reads 0 in the cycle after a reset edge.
  - A button held through reset produces one `pushed` pulse, at normal latency after `rst` falls.
- Reset asserted mid-count discards the partial count. No pulse is emitted for it.

## Timing
- Let E0 be the first rising edge at which `btn_in[i]` is stably new.
  - `sync2` reflects the new value after E1.
  - `btn_level[i]` and `pushed[i]`/`released[i]` change after edge E(1+DEBOUNCE_CYCLES).
  - Total latency is DEBOUNCE_CYCLES+2 edges, counting E0.
- Pulse width is exactly 1 clock. The minimum spacing between a `pushed` and the following `released` on the same bit is DEBOUNCE_CYCLES cycles.
- `any_pushed` is cycle-aligned with `pushed`.
- Without `BTN_DEBOUNCE_EN`, `btn_level` follows `sync2` one edge later, so latency is 3 edges (change after E2).

## Configuration
- `BTN_DEBOUNCE_EN` defined:
  - Per-bit counters and the stability rule above are compiled in.
- `BTN_DEBOUNCE_EN` undefined:
  - No counters are instantiated and `DEBOUNCE_CYCLES` is ignored.
  - `level <= sync2` every cycle, and edge pulses derive from `level` transitions.
  - Intended for simulation-speed benches and for boards with hardware-debounced buttons.

## Test plan
Run with `NUM_BTN=5` and `DEBOUNCE_CYCLES=4`, with `BTN_DEBOUNCE_EN` defined unless noted.
- Reset: hold `rst`=1 for 2 cycles with `btn_in`=5'b11111 → all outputs 0 during reset. After `rst`=0, a single `pushed`=5'b11111 pulse and `any_pushed`=1 appear 6 edges later.
- Clean press: `btn_in[3]` 0→1 held 20 cycles → `pushed[3]`=1 for exactly 1 cycle, at edge E5, with `btn_level[3]`=1 from then on. Releasing gives `released[3]`=1 for 1 cycle, 6 edges after the release edge.
- Bounce rejection: `btn_in[4]` toggles 1,0,1,0 with 2-cycle high/low periods, then settles at 1 → no pulse during the toggling, and exactly one `pushed[4]` 6 edges after settling.
- Simultaneous: `btn_in[3]` and `btn_in[4]` rise on the same edge → `pushed`=5'b11000 in one cycle and `any_pushed`=1. When `btn_in[4]` rises 2 cycles after `btn_in[3]` instead, the two pulses are 2 cycles apart.
- Reset mid-count: raise `btn_in[3]`, then assert `rst` at E3 for 1 cycle while still holding the button → no pulse before reset, and exactly one `pushed[3]` 6 edges after `rst` deasserts.
- `BTN_DEBOUNCE_EN` undefined: a 1-cycle glitch on `btn_in[0]` (width ≥1 clock) → `pushed[0]` at E2 and `released[0]` on the following edge.

Source files
------------

// File: rtl/button_conditioner.sv
// button_conditioner: per-button two-flop synchronizer, optional stability debouncer and edge pulses.
// Define BTN_DEBOUNCE_EN to compile in the per-bit debounce counters; otherwise level follows sync2.
module button_conditioner #(
  parameter int NUM_BTN         = 5,
  parameter int DEBOUNCE_CYCLES = 12000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] pushed,
  output logic [NUM_BTN-1:0] released,
  output logic               any_pushed
);

  // Next-cycle edge pulses, one bit per button; registered below.
  logic [NUM_BTN-1:0] push_d;
  logic [NUM_BTN-1:0] rel_d;

  // Illegal configurations (DEBOUNCE_CYCLES < 2) elaborate to no logic.
  if (DEBOUNCE_CYCLES >= 2) begin : g_cfg

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      logic sync1;
      logic sync2;
      logic level;

`ifdef BTN_DEBOUNCE_EN
      localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
      localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

      logic [CNT_W-1:0] cnt;
      logic             differ;
      logic             accept;

      // A change is accepted only after sync2 has disagreed with level for
      // DEBOUNCE_CYCLES consecutive edges; any agreement restarts the count.
      assign differ = (sync2 != level);
      assign accept = differ && (cnt == CNT_LAST);

      assign push_d[i] = accept & sync2;
      assign rel_d[i]  = accept & ~sync2;

      always_ff @(posedge clk) begin
        if (rst) begin
          sync1 <= 1'b0;
          sync2 <= 1'b0;
          level <= 1'b0;
          cnt   <= '0;
        end else begin
          sync1 <= btn_in[i];
          sync2 <= sync1;
          if (!differ) begin
            cnt <= '0;
          end else if (accept) begin
            level <= sync2;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
      end
`else
      assign push_d[i] = sync2 & ~level;
      assign rel_d[i]  = ~sync2 & level;

      always_ff @(posedge clk) begin
        if (rst) begin
          sync1 <= 1'b0;
          sync2 <= 1'b0;
          level <= 1'b0;
        end else begin
          sync1 <= btn_in[i];
          sync2 <= sync1;
          level <= sync2;
        end
      end
`endif

      assign btn_level[i] = level;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        pushed     <= '0;
        released   <= '0;
        any_pushed <= 1'b0;
      end else begin
        pushed     <= push_d;
        released   <= rel_d;
        any_pushed <= |push_d;
      end
    end
  end

endmodule
